// File: rtl/apb_slave_mem_if.sv
// rtl/apb_slave_mem_if.sv - APB bus bundle between master and one apb_slave_mem instance.
interface apb_slave_mem_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB word memory slave with programmable wait states and PSLVERR decode.
// Optional macro APB_SLV_WPROT_EN makes words below RO_WORDS read-only.
module apb_slave_mem #(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0,
  parameter int RO_WORDS    = 4
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_slave_mem_if.slave   bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;
`ifdef APB_SLV_WPROT_EN
  localparam logic WPROT = 1'b1;
`else
  localparam logic WPROT = 1'b0;
`endif

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic        write_q, write_d;
  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  logic [AW-1:0] idx;
  logic          ro_hit;
  logic          err;
  logic          pready;

  assign idx    = addr_q[AW+1:2];
  assign ro_hit = WPROT && write_q && ({{(32-AW){1'b0}}, idx} < 32'(RO_WORDS));
  // Decode works on the captured address so the setup-phase PADDR may change freely afterwards.
  assign err    = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0) || ro_hit;
  assign pready = (state_q == ACCESS) && bus.PSEL && bus.PENABLE && (cnt_q == 4'd0);

  assign bus.PREADY  = pready;
  assign bus.PSLVERR = pready && err;
  assign bus.PRDATA  = (pready && !write_q && !err) ? mem_q[idx] : 32'd0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    write_d = write_q;
    mem_d   = mem_q;
    case (state_q)
      IDLE: begin
        if (bus.PSEL && !bus.PENABLE) begin
          addr_d  = bus.PADDR;
          wdata_d = bus.PWDATA;
          strb_d  = bus.PSTRB;
          write_d = bus.PWRITE;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!bus.PSEL) begin
          state_d = IDLE;
        end else if (pready) begin
          state_d = IDLE;
          if (write_q && !err) begin
            for (int b = 0; b < 4; b++) begin
              if (strb_q[b]) mem_d[idx][8*b +: 8] = wdata_q[8*b +: 8];
            end
          end
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      strb_q  <= 4'd0;
      write_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      write_q <= write_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - Table-driven scoreboard bench for apb_slave_mem (0 and 3 wait-state instances).
module tb_apb_slave_mem;
`ifdef APB_SLV_WPROT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cur = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        pready, pslverr;
  logic [31:0] prdata;

  apb_slave_mem_if bus0();
  apb_slave_mem_if bus1();

  assign bus0.PSEL    = psel & ~cur;
  assign bus0.PENABLE = penable;
  assign bus0.PWRITE  = pwrite;
  assign bus0.PADDR   = paddr;
  assign bus0.PWDATA  = pwdata;
  assign bus0.PSTRB   = pstrb;
  assign bus1.PSEL    = psel & cur;
  assign bus1.PENABLE = penable;
  assign bus1.PWRITE  = pwrite;
  assign bus1.PADDR   = paddr;
  assign bus1.PWDATA  = pwdata;
  assign bus1.PSTRB   = pstrb;

  assign pready  = cur ? bus1.PREADY  : bus0.PREADY;
  assign pslverr = cur ? bus1.PSLVERR : bus0.PSLVERR;
  assign prdata  = cur ? bus1.PRDATA  : bus0.PRDATA;

  apb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(0), .RO_WORDS(4)) u_dut0 (
    .PCLK(clk), .PRESETn(rst_n), .bus(bus0)
  );
  apb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(3), .RO_WORDS(4)) u_dut1 (
    .PCLK(clk), .PRESETn(rst_n), .bus(bus1)
  );

  typedef struct {
    bit          dut;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    bit          err;
    int          waits;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          waits;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic xfer(input bit d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, input logic [31:0] er, input bit ee, input int ew,
                      input string tag);
    exp_t e;
    int   waits;
    bit   done;
    sb.push_back('{rdata: er, err: ee, waits: ew});
    @(posedge clk); #1;
    cur = d; psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = wd; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (pready) begin
        done = 1'b1;
      end else begin
        check({tag, "_wait_quiet"}, {31'd0, pslverr} | prdata, 32'd0);
        waits++;
        if (waits > 40) begin
          failures++;
          checks++;
          $display("FAIL %s_timeout: actual=no_pready required=pready", tag);
          done = 1'b1;
        end
      end
    end
    e = sb.pop_front();
    if (pready) begin
      check({tag, "_waits"}, 32'(waits), 32'(e.waits));
      check({tag, "_pslverr"}, {31'd0, pslverr}, {31'd0, e.err});
      check({tag, "_prdata"}, prdata, e.rdata);
    end
  endtask

  task automatic bus_idle();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    vecs.push_back('{0, 1, 32'h14, 32'hDEADBEEF, 4'b1111, 32'h0, 0, 0});
    vecs.push_back('{0, 0, 32'h14, 32'h0, 4'b0000, 32'hDEADBEEF, 0, 0});
    vecs.push_back('{0, 1, 32'h08, 32'hFFFFFFFF, 4'b1111, 32'h0, WP, 0});
    vecs.push_back('{0, 1, 32'h08, 32'h11223344, 4'b0101, 32'h0, WP, 0});
    vecs.push_back('{0, 0, 32'h08, 32'h0, 4'b0000, WP ? 32'h0 : 32'hFF22FF44, 0, 0});
    vecs.push_back('{0, 1, 32'h40, 32'h12345678, 4'b1111, 32'h0, 1, 0});
    vecs.push_back('{0, 0, 32'h06, 32'h0, 4'b0000, 32'h0, 1, 0});
    vecs.push_back('{0, 0, 32'h3C, 32'h0, 4'b0000, 32'h0, 0, 0});
    vecs.push_back('{0, 0, 32'h04, 32'h0, 4'b0000, 32'h0, 0, 0});
    vecs.push_back('{0, 1, 32'h3C, 32'hCAFEF00D, 4'b0000, 32'h0, 0, 0});
    vecs.push_back('{0, 0, 32'h3C, 32'h0, 4'b0000, 32'h0, 0, 0});
    vecs.push_back('{0, 1, 32'h3C, 32'h0BADF00D, 4'b1111, 32'h0, 0, 0});
    vecs.push_back('{0, 0, 32'h3C, 32'h0, 4'b0000, 32'h0BADF00D, 0, 0});
    vecs.push_back('{0, 1, 32'h0C, 32'hA5A5A5A5, 4'b1111, 32'h0, WP, 0});
    vecs.push_back('{0, 0, 32'h0C, 32'h0, 4'b0000, WP ? 32'h0 : 32'hA5A5A5A5, 0, 0});
    vecs.push_back('{0, 1, 32'h10, 32'hA5A5A5A5, 4'b1111, 32'h0, 0, 0});
    vecs.push_back('{0, 0, 32'h10, 32'h0, 4'b0000, 32'hA5A5A5A5, 0, 0});
    vecs.push_back('{1, 0, 32'h00, 32'h0, 4'b0000, 32'h0, 0, 3});
    vecs.push_back('{1, 1, 32'h3C, 32'h00000055, 4'b1111, 32'h0, 0, 3});
    vecs.push_back('{1, 0, 32'h3C, 32'h0, 4'b0000, 32'h00000055, 0, 3});
    vecs.push_back('{1, 0, 32'h3E, 32'h0, 4'b0000, 32'h0, 1, 3});

    repeat (2) @(posedge clk);
    #1;
    check("reset_pready0", {31'd0, bus0.PREADY}, 32'd0);
    check("reset_pslverr0", {31'd0, bus0.PSLVERR}, 32'd0);
    check("reset_prdata0", bus0.PRDATA, 32'd0);
    check("reset_pready1", {31'd0, bus1.PREADY}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      xfer(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
           vecs[i].rdata, vecs[i].err, vecs[i].waits, $sformatf("vec%0d", i));
    end
    bus_idle();

    // PENABLE straight from idle must be ignored.
    @(posedge clk); #1;
    cur = 1'b0; psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h14;
    repeat (2) begin
      @(negedge clk);
      check("no_setup_pready", {31'd0, pready}, 32'd0);
    end
    bus_idle();

    // Protocol abort: PSEL drops after two access cycles of a 3-wait write.
    @(posedge clk); #1;
    cur = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10;
    pwdata = 32'h12345678; pstrb = 4'b1111;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("abort_pready", {31'd0, pready}, 32'd0);
    end
    bus_idle();
    xfer(1, 0, 32'h10, 32'h0, 4'b0000, 32'h0, 0, 3, "abort_read");
    bus_idle();

    // Reset asserted mid-access.
    @(posedge clk); #1;
    cur = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10;
    pwdata = 32'h12345678; pstrb = 4'b1111;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("reset_mid_pready", {31'd0, pready}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1, 0, 32'h10, 32'h0, 4'b0000, 32'h0, 0, 3, "reset_read1");
    xfer(0, 0, 32'h14, 32'h0, 4'b0000, 32'h0, 0, 0, "reset_read0");
    bus_idle();

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
